// File: rtl/bram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_arb_pkg
// Description : Shared types and constants for the two-port BRAM arbiter:
//               FSM state encoding, default widths, requester indices.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_arb_pkg;

    // Default RAM geometry: 16 words of 16 bits.
    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 4;

    // Requester indices as carried in the grant / last_grant bit.
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Transaction FSM encoding.
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way winner select plus the last_grant register.
//               Round-robin by default; with ARB_FIXED_PRIO_EN defined,
//               requester 0 always wins simultaneous requests.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import bram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic grant_en,
    output logic any_req,
    output logic winner
);

    logic last_grant_q;
    logic last_grant_d;

    // Winner select and last_grant next-value.
    always_comb begin
        any_req      = req0 | req1;
        last_grant_d = last_grant_q;
`ifdef ARB_FIXED_PRIO_EN
        // Fixed priority: requester 1 only when requester 0 is idle.
        winner = req0 ? REQ0 : REQ1;
`else
        // Round-robin: on contention, the one not granted last time wins.
        if (req0 && req1) begin
            winner = ~last_grant_q;
        end else if (req0) begin
            winner = REQ0;
        end else begin
            winner = REQ1;
        end
`endif
        if (grant_en) begin
            last_grant_d = winner;
        end
    end

    // last_grant resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Shares one single-port block RAM between two req/ack
//               requesters. One-word read/write transactions, RAM read
//               latency accounted for, read data returned with the ack pulse.
//               Optional build macro ARB_FIXED_PRIO_EN selects fixed priority
//               (requester 0 first) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int READ_LATENCY = 1              // 1, or 2 with RAM output register
)(
    input  logic              clk,
    input  logic              rst_n,
    // requester 0
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    // requester 1
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    // RAM port
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta,
    // status
    output logic              busy
);

    // WAIT spends READ_LATENCY cycles in state terms; the counter holds the
    // number of extra cycles beyond the first.
    localparam int          LAT_M1   = (READ_LATENCY > 1) ? (READ_LATENCY - 1) : 0;
    localparam int          CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_M1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                win_q, win_d;
    logic                ena_q, ena_d;
    logic                wea_q, wea_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [DATA_W-1:0]   dina_q, dina_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                busy_q, busy_d;

    logic                grant_en;
    logic                any_req;
    logic                winner;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .grant_en (grant_en),
        .any_req  (any_req),
        .winner   (winner)
    );

    // Transaction FSM: next state, RAM port values, acks and read capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        ena_d    = 1'b0;
        wea_d    = 1'b0;
        addra_d  = addra_q;
        dina_d   = dina_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        grant_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_en = 1'b1;
                    win_d    = winner;
                    ena_d    = 1'b1;
                    if (winner == REQ0) begin
                        wea_d   = we0;
                        addra_d = addr0;
                        dina_d  = wdata0;
                    end else begin
                        wea_d   = we1;
                        addra_d = addr1;
                        dina_d  = wdata1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // RAM samples at the edge closing this cycle.
                if (wea_q) begin
                    ack0_d  = (win_q == REQ0);
                    ack1_d  = (win_q == REQ1);
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    // douta is valid during this cycle; capture at its end.
                    if (win_q == REQ0) begin
                        rdata0_d = douta;
                    end else begin
                        rdata1_d = douta;
                    end
                    ack0_d  = (win_q == REQ0);
                    ack1_d  = (win_q == REQ1);
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            win_q    <= REQ0;
            ena_q    <= 1'b0;
            wea_q    <= 1'b0;
            addra_q  <= '0;
            dina_q   <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            ena_q    <= ena_d;
            wea_q    <= wea_d;
            addra_q  <= addra_d;
            dina_q   <= dina_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    assign ena    = ena_q;
    assign wea    = wea_q;
    assign addra  = addra_q;
    assign dina   = dina_q;
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_port_arbiter
// Description : Self-checking bench for bram_port_arbiter. Instance A uses
//               READ_LATENCY=1, instance B uses READ_LATENCY=2 with a RAM
//               model that has a registered output. Expected timing comes from
//               a transaction-level timeline model, expected data from a
//               shadow copy of the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int RL = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A (READ_LATENCY = 1) ----------------
    logic          req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, ena, wea, busy;
    logic [DW-1:0] rdata0, rdata1, dina;
    logic [AW-1:0] addra;
    logic [DW-1:0] douta = '0;
    logic [DW-1:0] mem_a [16] = '{default: '0};

    bram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(RL)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta), .busy(busy)
    );

    // Single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (ena) begin
            if (wea) mem_a[addra] <= dina;
            else     douta <= mem_a[addra];
        end
    end

    // ---------------- instance B (READ_LATENCY = 2) ----------------
    logic          req0_b = 0, we0_b = 0, req1_b = 0, we1_b = 0;
    logic [AW-1:0] addr0_b = '0, addr1_b = '0;
    logic [DW-1:0] wdata0_b = '0, wdata1_b = '0;
    logic          ack0_b, ack1_b, ena_b, wea_b, busy_b;
    logic [DW-1:0] rdata0_b, rdata1_b, dina_b;
    logic [AW-1:0] addra_b;
    logic [DW-1:0] s1_b = '0;
    logic [DW-1:0] douta_b = '0;
    logic [DW-1:0] mem_b [16] = '{14: 16'h7FFF, default: '0};

    bram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b), .ack0(ack0_b), .rdata0(rdata0_b),
        .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b), .ack1(ack1_b), .rdata1(rdata1_b),
        .ena(ena_b), .wea(wea_b), .addra(addra_b), .dina(dina_b), .douta(douta_b), .busy(busy_b)
    );

    // RAM with output register: data appears two edges after sampling.
    always @(posedge clk) begin
        if (ena_b) begin
            if (wea_b) mem_b[addra_b] <= dina_b;
            else       s1_b <= mem_b[addra_b];
        end
        douta_b <= s1_b;
    end

    // ---------------- reference model state ----------------
    int            checks = 0;
    int            passes = 0;
    int            fails  = 0;
    logic [DW-1:0] shadow [16];
    logic [DW-1:0] exp_rd [2];
    int            last_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One round of requests on instance A. The model lays out the expected
    // timeline: grants in arbitration order, ack 1 (write) or 1+RL (read)
    // cycles after the grant, next grant two cycles after the previous ack.
    // n counts sampling points after edges, n=0 being the edge that sees req.
    task automatic txn(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int            ord [2];
        int            nord;
        int            gnt [2];
        int            ackn [2];
        bit            w [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        logic [DW-1:0] rexp [2];
        int            g;
        int            endn;
        w[0] = w0; w[1] = w1; a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        gnt[0] = -100; gnt[1] = -100; ackn[0] = -100; ackn[1] = -100;
        ord[1] = 0;
        if (r0 && r1) begin
`ifdef ARB_FIXED_PRIO_EN
            ord[0] = 0;
`else
            ord[0] = (last_g == 1) ? 0 : 1;
`endif
            ord[1] = 1 - ord[0];
            nord = 2;
        end else begin
            ord[0] = r0 ? 0 : 1;
            nord = 1;
        end
        rexp[0] = exp_rd[0];
        rexp[1] = exp_rd[1];
        g = 0;
        endn = 0;
        for (int i = 0; i < nord; i++) begin
            int r;
            r = ord[i];
            gnt[r]  = g;
            ackn[r] = g + 1 + (w[r] ? 0 : RL);
            if (w[r]) shadow[a[r]] = d[r];
            else      rexp[r] = shadow[a[r]];
            g      = ackn[r] + 2;
            endn   = ackn[r] + 1;
            last_g = r;
        end
        exp_rd[0] = rexp[0];
        exp_rd[1] = rexp[1];

        @(negedge clk);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        for (int n = 0; n <= endn; n++) begin
            @(posedge clk);
            #1;
            chk("ena",  ena,  (n == gnt[0]) || (n == gnt[1]));
            chk("busy", busy, (n >= gnt[0] && n <= ackn[0]) || (n >= gnt[1] && n <= ackn[1]));
            chk("ack0", ack0, n == ackn[0]);
            chk("ack1", ack1, n == ackn[1]);
            for (int r = 0; r < 2; r++) begin
                if (n == gnt[r]) begin
                    chk("wea",   wea,   w[r]);
                    chk("addra", addra, a[r]);
                    if (w[r]) chk("dina", dina, d[r]);
                end
            end
            if (n == ackn[0]) chk("rdata0", rdata0, rexp[0]);
            if (n == ackn[1]) chk("rdata1", rdata1, rexp[1]);
            @(negedge clk);
            if (n == ackn[0]) req0 = 0;
            if (n == ackn[1]) req1 = 0;
        end
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        last_g = 1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ena",    ena,    0);
        chk("rst_wea",    wea,    0);
        chk("rst_addra",  addra,  0);
        chk("rst_dina",   dina,   0);
        chk("rst_ack0",   ack0,   0);
        chk("rst_ack1",   ack1,   0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_busy",   busy,   0);
        chk("rst_busy_b", busy_b, 0);
        @(negedge clk);
        rst_n = 1;

        // Instance B: read of preloaded addr 14, latency 2.
        @(negedge clk);
        req1_b = 1; we1_b = 0; addr1_b = 4'd14;
        for (int n = 0; n <= 4; n++) begin
            @(posedge clk);
            #1;
            chk("b_ack1",   ack1_b,   n == 3);
            chk("b_ack0",   ack0_b,   0);
            chk("b_rdata1", rdata1_b, (n >= 3) ? 32'h7FFF : 32'h0);
            chk("b_busy",   busy_b,   n <= 3);
            if (n == 0) chk("b_addra", addra_b, 14);
            chk("b_ena",    ena_b,    n == 0);
            @(negedge clk);
            if (n == 3) req1_b = 0;
        end

        // Single write then read on requester 0.
        txn(1, 1, 4'd3, 16'h00FF, 0, 0, 4'd0, 16'h0);
        txn(1, 0, 4'd3, 16'h0000, 0, 0, 4'd0, 16'h0);
        chk("wr_rd_00FF", rdata0, 16'h00FF);

        // Sustained contention: 8 grants, alternating under round-robin.
        for (int i = 0; i < 4; i++) begin
            txn(1, i[0], 4'(i), 16'(16'h1000 + i), 1, ~i[0], 4'(i + 8), 16'(16'h2000 + i));
        end

        // Write fill sweep by requester 0, read back by requester 1.
        for (int i = 0; i < 16; i++) begin
            v = (32'd1 << (i + 1)) - 32'd1;
            txn(1, 1, 4'(i), v[15:0], 0, 0, 4'd0, 16'h0);
        end
        for (int i = 0; i < 16; i++) begin
            v = (32'd1 << (i + 1)) - 32'd1;
            txn(0, 0, 4'd0, 16'h0, 1, 0, 4'(i), 16'h0);
            chk("fill_rd", rdata1, v[15:0]);
        end
        chk("fill_15", rdata1, 16'hFFFF);

        // Randomized rounds.
        for (int i = 0; i < 30; i++) begin
            int unsigned p;
            p = $urandom_range(1, 3);
            txn(p[0], 1'($urandom), 4'($urandom), 16'($urandom),
                p[1], 1'($urandom), 4'($urandom), 16'($urandom));
        end

        // Reset in the middle of a read.
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 4'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("mid_ena",    ena,    0);
        chk("mid_wea",    wea,    0);
        chk("mid_ack0",   ack0,   0);
        chk("mid_ack1",   ack1,   0);
        chk("mid_busy",   busy,   0);
        chk("mid_rdata0", rdata0, 0);
        req0 = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        last_g = 1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            chk("post_ack0", ack0, 0);
            chk("post_ack1", ack1, 0);
            chk("post_busy", busy, 0);
        end

        // Contention right after reset: requester 0 first.
        txn(1, 0, 4'd3, 16'h0, 1, 0, 4'd15, 16'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
